// File: rtl/multi_pulse_generator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pulse_gen_pkg                                                |
// | Description : Shared encodings for the multi-channel pulse generator:      |
// |               channel mode values and the per-channel FSM state type.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package pulse_gen_pkg;

    // Per-channel operating mode, as presented on the mode bus (2 bits/channel)
    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_CONT    = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    localparam logic [1:0] MODE_BURST   = 2'b11;

    // Per-channel FSM state
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multi_pulse_generator_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : multi_pulse_generator_if                                     |
// | Description : Control/status bundle for the multi-channel pulse generator. |
// |   period, high, burst_len : CH*W  per-channel fields, channel i at [i*W+:W]|
// |   mode                    : CH*2  per-channel mode                         |
// |   start, stop             : CH    one-cycle requests                       |
// |   pulse, busy, done       : CH    per-channel status                       |
// |   master modport drives the controls; slave modport is the generator.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface multi_pulse_generator_if #(
    parameter int CH = 4,
    parameter int W  = 8
);
    logic [CH*W-1:0] period;
    logic [CH*W-1:0] high;
    logic [CH*2-1:0] mode;
    logic [CH*W-1:0] burst_len;
    logic [CH-1:0]   start;
    logic [CH-1:0]   stop;
    logic [CH-1:0]   pulse;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   done;

    modport master (
        output period, high, mode, burst_len, start, stop,
        input  pulse, busy, done
    );

    modport slave (
        input  period, high, mode, burst_len, start, stop,
        output pulse, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/multi_pulse_generator_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pulse_channel                                                |
// | Description : One independent pulse channel. IDLE/RUN FSM with shadowed    |
// |               period/high/mode that reload only at period boundaries.      |
// |   clk, rst (sync, active-low)                                              |
// |   period, high, burst_len [W], mode [2], start, stop : controls            |
// |   pulse, busy, done                                  : registered status   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pulse_channel
    import pulse_gen_pkg::*;
#(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [W-1:0] period,
    input  wire logic [W-1:0] high,
    input  wire logic [1:0]   mode,
    input  wire logic [W-1:0] burst_len,
    input  wire logic         start,
    input  wire logic         stop,
    output logic              pulse,
    output logic              busy,
    output logic              done
);

    localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [W-1:0] phase_q, phase_d;
    logic [W-1:0] per_q,   per_d;
    logic [W-1:0] high_q,  high_d;
    logic [1:0]   mode_q,  mode_d;
    logic [W-1:0] rem_q,   rem_d;
    logic         pulse_q, pulse_d;
    logic         busy_q,  busy_d;
    logic         done_q,  done_d;

    logic [W-1:0] w_phase_inc;
    logic         w_boundary;
    logic         w_finished;

    assign w_phase_inc = phase_q + C_ONE;
    // per_q is never 0 while in RUN, so the subtraction cannot wrap there
    assign w_boundary  = (phase_q == (per_q - C_ONE));
    // Normal completion is decided by the mode of the period just ending
    assign w_finished  = (mode_q == MODE_ONESHOT) ||
                         ((mode_q == MODE_BURST) && (rem_q == C_ONE));

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        per_d   = per_q;
        high_d  = high_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        pulse_d = pulse_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pulse_d = 1'b0;
                busy_d  = 1'b0;
                if (start && (mode != MODE_OFF) && (period != '0)) begin
                    state_d = ST_RUN;
                    per_d   = period;
                    high_d  = high;
                    mode_d  = mode;
                    rem_d   = (burst_len == '0) ? C_ONE : burst_len;
                    phase_d = '0;
                    // Output for phase 0 is registered now so it appears next cycle
                    pulse_d = (high != '0);
                    busy_d  = 1'b1;
                end
            end

            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    pulse_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (w_boundary) begin
                    if (w_finished) begin
                        state_d = ST_IDLE;
                        pulse_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if ((mode == MODE_OFF) || (period == '0)) begin
                        // Reloaded settings disable the channel: quiet exit
                        state_d = ST_IDLE;
                        pulse_d = 1'b0;
                        busy_d  = 1'b0;
                    end else begin
                        per_d   = period;
                        high_d  = high;
                        mode_d  = mode;
                        phase_d = '0;
                        pulse_d = (high != '0);
                        if (mode_q == MODE_BURST) begin
                            rem_d = rem_q - C_ONE;
                        end
                    end
                end else begin
                    phase_d = w_phase_inc;
                    pulse_d = (w_phase_inc < high_q);
                end
            end

            default: begin
                state_d = ST_IDLE;
                pulse_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            per_q   <= '0;
            high_q  <= '0;
            mode_q  <= MODE_OFF;
            rem_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            per_q   <= per_d;
            high_q  <= high_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign pulse = pulse_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: rtl/multi_pulse_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multi_pulse_generator                                        |
// | Description : CH fully independent programmable pulse channels.            |
// |   clk : rising-edge clock                                                  |
// |   rst : synchronous, active-low reset                                      |
// |   bus : multi_pulse_generator_if.slave (controls in, pulse/busy/done out)  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module multi_pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    multi_pulse_generator_if.slave  bus
);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        pulse_channel #(
            .W (W)
        ) u_channel (
            .clk       (clk),
            .rst       (rst),
            .period    (bus.period[i*W +: W]),
            .high      (bus.high[i*W +: W]),
            .mode      (bus.mode[i*2 +: 2]),
            .burst_len (bus.burst_len[i*W +: W]),
            .start     (bus.start[i]),
            .stop      (bus.stop[i]),
            .pulse     (bus.pulse[i]),
            .busy      (bus.busy[i]),
            .done      (bus.done[i])
        );
    end

endmodule
`default_nettype wire
